// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipe.
// Tracks in-flight writers in EX/MEM/WB, stalls ID on unresolvable RAW hazards,
// flushes IF/ID on redirects, freezes on data-memory wait, and counts events.
module pipeline_hazard_ctrl #(
  parameter bit          FWD_EN    = 1'b1,
  parameter bit          RF_BYPASS = 1'b1,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_is_branch,
  input  logic [4:0]           id_dest,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic                 redirect_taken,
  input  logic                 dmem_wait,
  output logic                 pc_write,
  output logic                 ifid_enable,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } sb_ent_t;

  sb_ent_t ex_q, mem_q, wb_q;
  sb_ent_t ex_d, mem_d, wb_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_hit, mem_hit, wb_hit;
  logic load_use, br_haz, nofwd, wb_haz, stall, freeze;

  // One source register against one in-flight writer; $0 never hazards.
  function automatic logic hit(input sb_ent_t e, input logic [4:0] r, input logic use_r);
    return use_r && e.v && e.rw && (e.dest == r) && (r != 5'd0);
  endfunction

  // Hazard detection and pipeline control, priority freeze > stall > redirect.
  always_comb begin
    ex_hit  = id_valid && (hit(ex_q,  id_rs, id_uses_rs) || hit(ex_q,  id_rt, id_uses_rt));
    mem_hit = id_valid && (hit(mem_q, id_rs, id_uses_rs) || hit(mem_q, id_rt, id_uses_rt));
    wb_hit  = id_valid && (hit(wb_q,  id_rs, id_uses_rs) || hit(wb_q,  id_rt, id_uses_rt));

    load_use = ex_hit && ex_q.mr;
    br_haz   = id_is_branch && (ex_hit || (mem_hit && mem_q.mr));
    nofwd    = !FWD_EN && (ex_hit || mem_hit);
    wb_haz   = !RF_BYPASS && wb_hit;
    stall    = load_use || br_haz || nofwd || wb_haz;
    freeze   = dmem_wait;

    pc_write    = !freeze && !stall;
    ifid_enable = !freeze && !stall;
    idex_flush  = stall && !freeze;
    ifid_flush  = redirect_taken && !stall && !freeze;
  end

  // Scoreboard advance: hold on freeze, insert a bubble into EX on stall.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = stall ? '0 : '{v: id_valid, dest: id_dest, rw: id_regwrite, mr: id_memread};
    end
  end

  // Saturating event counters; stall/flush are both low during freeze so they hold.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (idex_flush && (stall_cnt_q != {CNT_WIDTH{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_flush && (flush_cnt_q != {CNT_WIDTH{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: main DUT with forwarding/bypass and 4-bit counters, plus a
// no-forward/no-bypass instance sharing the same inputs for the RAW-stall paths.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_is_branch, id_regwrite, id_memread;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       redirect_taken, dmem_wait;

  logic       pc_write, ifid_enable, ifid_flush, idex_flush;
  logic [3:0] stall_count, flush_count;
  logic       pc_write2, ifid_enable2, ifid_flush2, idex_flush2;
  logic [3:0] stall_count2, flush_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .redirect_taken(redirect_taken), .dmem_wait(dmem_wait),
    .pc_write(pc_write), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .stall_count(stall_count), .flush_count(flush_count));

  pipeline_hazard_ctrl #(.FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .redirect_taken(redirect_taken), .dmem_wait(dmem_wait),
    .pc_write(pc_write2), .ifid_enable(ifid_enable2), .ifid_flush(ifid_flush2),
    .idex_flush(idex_flush2), .stall_count(stall_count2), .flush_count(flush_count2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic br,
                        input logic [4:0] dst, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_is_branch = br; id_dest = dst; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic bubble();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    bubble();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; redirect_taken = 1'b0; dmem_wait = 1'b0;
    bubble();
    #12;
    // reset state
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);
    chk("rst_pc_write",    pc_write,    1);
    chk("rst_ifid_enable", ifid_enable, 1);
    chk("rst_idex_flush",  idex_flush,  0);
    chk("rst_ifid_flush",  ifid_flush,  0);
    @(negedge clk); reset = 1'b0;
    tick();

    // T1 load-use: lw $8 then add using $8
    set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd8, 1, 1);
    chk("t1_lw_no_stall", pc_write, 1);
    tick();
    set_id(1, 5'd8, 1, 5'd0, 0, 0, 5'd3, 1, 0);
    chk("t1_pc_write",    pc_write,    0);
    chk("t1_ifid_enable", ifid_enable, 0);
    chk("t1_idex_flush",  idex_flush,  1);
    chk("t1_ifid_flush",  ifid_flush,  0);
    tick();
    chk("t1_pc_write_n1",   pc_write,    1);
    chk("t1_idex_flush_n1", idex_flush,  0);
    chk("t1_stall_count",   stall_count, 1);
    drain();

    // T2 $0 destination never hazards
    set_id(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1);
    tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 0, 5'd2, 1, 0);
    chk("t2_pc_write",   pc_write,   1);
    chk("t2_idex_flush", idex_flush, 0);
    drain();

    // T3/T4 branch on load: 2 stalls, redirect ignored while stalled
    set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd9, 1, 1);
    tick();
    set_id(1, 5'd9, 1, 5'd10, 1, 1, 5'd0, 0, 0);
    redirect_taken = 1'b1; #1;
    chk("t3_c1_pc_write",   pc_write,   0);
    chk("t3_c1_idex_flush", idex_flush, 1);
    chk("t4_c1_ifid_flush", ifid_flush, 0);
    tick();
    chk("t3_c2_pc_write",   pc_write,   0);
    chk("t3_c2_idex_flush", idex_flush, 1);
    chk("t4_c2_ifid_flush", ifid_flush, 0);
    chk("t4_flush_count_hold", flush_count, 0);
    tick();
    chk("t3_c3_pc_write",   pc_write,    1);
    chk("t3_c3_ifid_flush", ifid_flush,  1);
    chk("t3_c3_idex_flush", idex_flush,  0);
    chk("t3_stall_count",   stall_count, 3);
    tick();
    redirect_taken = 1'b0; #1;
    chk("t3_flush_count", flush_count, 1);
    chk("t3_ifid_flush_off", ifid_flush, 0);
    drain();

    // Branch on ALU result in EX: exactly 1 stall
    set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd4, 1, 0);
    tick();
    set_id(1, 5'd4, 1, 5'd0, 0, 1, 5'd0, 0, 0);
    chk("br_alu_c1_stall", pc_write, 0);
    tick();
    chk("br_alu_c2_go",      pc_write,    1);
    chk("br_alu_stall_count", stall_count, 4);
    drain();

    // T5 freeze over a load-use hazard
    set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd8, 1, 1);
    tick();
    set_id(1, 5'd8, 1, 5'd0, 0, 0, 5'd3, 1, 0);
    dmem_wait = 1'b1; redirect_taken = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_pc_write",    pc_write,    0);
      chk("t5_ifid_enable", ifid_enable, 0);
      chk("t5_idex_flush",  idex_flush,  0);
      chk("t5_ifid_flush",  ifid_flush,  0);
      tick();
      chk("t5_stall_hold",  stall_count, 4);
      chk("t5_flush_hold",  flush_count, 1);
    end
    dmem_wait = 1'b0; redirect_taken = 1'b0; #1;
    chk("t5_release_stall", idex_flush, 1);
    tick();
    chk("t5_after_pc_write", pc_write,    1);
    chk("t5_stall_count",    stall_count, 5);
    drain();

    // T6 saturation: one stall per lw/use pair
    for (int i = 0; i < 20; i++) begin
      set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd8, 1, 1);
      tick();
      set_id(1, 5'd8, 1, 5'd0, 0, 0, 5'd3, 1, 0);
      tick();
      if (i == 4) chk("t6_count_mid", stall_count, 10);
    end
    chk("t6_saturated", stall_count, 15);

    // Reset mid-stall clears without a clock edge
    set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd8, 1, 1);
    tick();
    set_id(1, 5'd8, 1, 5'd0, 0, 0, 5'd3, 1, 0);
    chk("t6_pre_reset_stall", pc_write, 0);
    reset = 1'b1; #1;
    chk("t6_rst_stall_count", stall_count, 0);
    chk("t6_rst_flush_count", flush_count, 0);
    chk("t6_rst_pc_write",    pc_write,    1);
    chk("t6_rst_idex_flush",  idex_flush,  0);
    tick();
    reset = 1'b0; #1;
    chk("t6_no_pending_stall", pc_write, 1);
    bubble();

    // No forwarding / no RF bypass: ALU result dependence stalls until WB retires
    set_id(1, 5'd0, 0, 5'd0, 0, 0, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 0, 5'd6, 1, 0);
    chk("fwd_ex_no_stall",  pc_write,  1);
    chk("nofwd_ex_stall",   pc_write2, 0);
    tick();
    chk("nofwd_mem_stall",  pc_write2, 0);
    tick();
    chk("nobyp_wb_stall",   pc_write2, 0);
    chk("nobyp_idex_flush", idex_flush2, 1);
    tick();
    chk("nofwd_clear",      pc_write2, 1);
    chk("nofwd_stall_count", stall_count2, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
